// File: rtl/ika2151_pkg.sv
// ika2151_pkg: shared widths, serial word layout and saturation for the IKA2151 output stage
package ika2151_pkg;
  localparam int ACC_W = 19;
  localparam int OUT_W = 16;
  localparam int MANT_W = 10;
  localparam int EXP_W = 3;
  localparam int SO_MANT_LSB = 3;
  localparam int SO_EXP_LSB = 13;
  localparam logic signed [ACC_W-1:0] SAT_MAX = 32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -32768;
  function automatic logic [OUT_W-1:0] sat16(input logic signed [ACC_W-1:0] a);
    return a > SAT_MAX ? 16'h7fff : a < SAT_MIN ? 16'h8000 : a[OUT_W-1:0];
  endfunction
  // bits below SO_MANT_LSB are zero padding
  function automatic logic [OUT_W-1:0] so_word(input logic [MANT_W-1:0] m, input logic [EXP_W-1:0] e);
    logic [OUT_W-1:0] w;
    w = '0;
    w[SO_MANT_LSB +: MANT_W] = m;
    w[SO_EXP_LSB +: EXP_W] = e;
    return w;
  endfunction
endpackage

// File: rtl/ika2151_fpenc.sv
// ika2151_fpenc: 16-bit signed sample to 10-bit mantissa / 3-bit exponent float
module ika2151_fpenc
  import ika2151_pkg::*;
(
  input  logic signed [OUT_W-1:0]  i_s,
  output logic        [MANT_W-1:0] o_m,
  output logic        [EXP_W-1:0]  o_e
);
  always_comb begin
    o_e = 3'd7;
    // descending scan so the smallest exponent whose upper bits are pure sign wins
    for (int k = 6; k >= 1; k--)
      if ((i_s >>> (8 + k)) == {OUT_W{i_s[OUT_W-1]}}) o_e = EXP_W'(k);
    o_m = MANT_W'(i_s >>> (o_e - 3'd1));
  end
endmodule

// File: rtl/ika2151_acc.sv
// ika2151_acc: L/R carrier accumulator with frame-end saturation and serial float DAC output
module ika2151_acc
  import ika2151_pkg::*;
(
  input  logic              i_EMUCLK,
  input  logic              i_MRST_n,
  input  logic              i_phi1_NCEN_n,
  input  logic              i_CYCLE_31,
  input  logic              i_ACC_OPADD,
  input  logic [13:0]       i_ACC_OPOUT,
  input  logic [1:0]        i_RL,
  output logic              o_SO,
  output logic [OUT_W-1:0]  o_EMU_L,
  output logic [OUT_W-1:0]  o_EMU_R,
  output logic              o_EMU_SAMPLE
);
  logic [4:0] cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d, op, sum_l, sum_r;
  logic [OUT_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d, word;
  logic so_q, so_d, smp_q, smp_d, tick, fin;
  logic [MANT_W-1:0] m_l, m_r;
  logic [EXP_W-1:0] e_l, e_r;

  ika2151_fpenc u_enc_l (.i_s(hold_l_q), .o_m(m_l), .o_e(e_l));
  ika2151_fpenc u_enc_r (.i_s(hold_r_q), .o_m(m_r), .o_e(e_r));

  always_comb begin
    tick = ~i_phi1_NCEN_n;
    fin = tick & i_CYCLE_31;
    op = {{(ACC_W-14){i_ACC_OPOUT[13]}}, i_ACC_OPOUT};
    sum_l = acc_l_q + ((i_ACC_OPADD & i_RL[0]) ? op : '0);
    sum_r = acc_r_q + ((i_ACC_OPADD & i_RL[1]) ? op : '0);
    acc_l_d = !tick ? acc_l_q : fin ? '0 : sum_l;
    acc_r_d = !tick ? acc_r_q : fin ? '0 : sum_r;
    hold_l_d = fin ? sat16(sum_l) : hold_l_q;
    hold_r_d = fin ? sat16(sum_r) : hold_r_q;
    cnt_d = !tick ? cnt_q : fin ? 5'd0 : cnt_q + 5'd1;
    // first half of the frame carries left, second half right
    word = cnt_q[4] ? so_word(m_r, e_r) : so_word(m_l, e_l);
    so_d = tick ? word[cnt_q[3:0]] : so_q;
    smp_d = tick ? i_CYCLE_31 : smp_q;
  end

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n)
    if (!i_MRST_n) begin
      cnt_q <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      so_q <= 1'b0;
      smp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      so_q <= so_d;
      smp_q <= smp_d;
    end

  assign o_SO = so_q;
  assign o_EMU_L = hold_l_q;
  assign o_EMU_R = hold_r_q;
  assign o_EMU_SAMPLE = smp_q;
endmodule

// File: tb/tb_ika2151_acc.sv
// tb_ika2151_acc: directed frame-level checks of accumulation, saturation, float encode and serial output
module tb_ika2151_acc;
  logic clk = 1'b0, rst_n = 1'b0, ncen = 1'b1, cyc = 1'b0, add = 1'b0;
  logic [13:0] opout = '0;
  logic [1:0] rl = '0;
  logic so, smp;
  logic [15:0] emu_l, emu_r;
  logic [31:0] sow = '0;
  logic psmp = 1'b0;
  int s = 0, checks = 0, failures = 0;

  ika2151_acc dut (
    .i_EMUCLK(clk), .i_MRST_n(rst_n), .i_phi1_NCEN_n(ncen), .i_CYCLE_31(cyc),
    .i_ACC_OPADD(add), .i_ACC_OPOUT(opout), .i_RL(rl),
    .o_SO(so), .o_EMU_L(emu_l), .o_EMU_R(emu_r), .o_EMU_SAMPLE(smp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic slot(input logic a, input logic [13:0] v, input logic [1:0] r);
    add = a; opout = v; rl = r; cyc = (s == 31); ncen = 1'b1;
    @(posedge clk); #1;
    check("sample_hold", smp, psmp);
    ncen = 1'b0;
    @(posedge clk); #1;
    sow[s] = so;
    psmp = (s == 31);
    check("sample", smp, psmp);
    ncen = 1'b1;
    s = (s == 31) ? 0 : s + 1;
  endtask

  task automatic frame(input logic [31:0] mask, input logic [13:0] v, input logic [1:0] r,
                       input logic [15:0] el, input logic [15:0] er, input logic [31:0] eso);
    for (int i = 0; i < 32; i++) slot(mask[i], v, r);
    check("emu_l", emu_l, el);
    check("emu_r", emu_r, er);
    check("so_word", sow, eso);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_l", emu_l, 16'h0);
    check("rst_so", so, 1'b0);
    frame(32'h0, 14'h0, 2'b00, 16'h0000, 16'h0000, 32'h2000_2000);
    frame(32'h0, 14'h0, 2'b00, 16'h0000, 16'h0000, 32'h2000_2000);
    frame(32'h1, 14'd100, 2'b01, 16'd100, 16'h0000, 32'h2000_2000);
    frame(32'h0, 14'h0, 2'b00, 16'h0000, 16'h0000, 32'h2000_2320);
    frame(32'hffff_ffff, 14'h1fff, 2'b11, 16'h7fff, 16'h7fff, 32'h2000_2000);
    frame(32'hffff_ffff, 14'h2000, 2'b11, 16'h8000, 16'h8000, 32'heff8_eff8);
    frame(32'h1, 14'd1000, 2'b01, 16'd1000, 16'h0000, 32'hf000_f000);
    frame(32'h8000_0000, 14'd5, 2'b01, 16'd5, 16'h0000, 32'h2000_4fa0);
    frame(32'hffff_ffff, 14'd100, 2'b00, 16'h0000, 16'h0000, 32'h2000_2028);
    frame(32'h1, 14'd100, 2'b10, 16'h0000, 16'd100, 32'h2000_2000);
    for (int i = 0; i < 10; i++) slot(1'b1, 14'd50, 2'b11);
    rst_n = 1'b0;
    #2;
    check("mrst_l", emu_l, 16'h0);
    check("mrst_r", emu_r, 16'h0);
    check("mrst_so", so, 1'b0);
    check("mrst_smp", smp, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    s = 0;
    psmp = 1'b0;
    frame(32'h1, 14'd7, 2'b11, 16'd7, 16'd7, 32'h2000_2000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ika2151_acc.md
# ika2151_acc

Output accumulator and serial DAC encoder of the IKA2151 core; sits directly downstream of the operator stage. Each phi1 slot it sums carrier outputs from the operator stage into left/right channel accumulators, using the per-slot RL routing bits. At each frame end it saturates both sums to 16 bits, converts them to the 10-bit-mantissa/3-bit-exponent floating format, and shifts them out on SO, left then right. It also provides parallel 16-bit emulator samples.

## Interface
Parameters:
- none

Ports:
- i_EMUCLK  in  1  emulator master clock; all state on rising edge
- i_MRST_n  in  1  reset, asynchronous, active-low
- i_phi1_NCEN_n  in  1  phi1 negative-edge clock enable; a "tick" is a rising i_EMUCLK edge with this low
- i_CYCLE_31  in  1  high during slot 31, the last slot of the 32-slot frame
- i_ACC_OPADD  in  1  current slot is a carrier; add i_ACC_OPOUT
- i_ACC_OPOUT  in  14  signed operator output for current slot
- i_RL  in  2  routing for current slot's channel: bit0 = L enable, bit1 = R enable
- o_SO  out  1  serial DAC data
- o_EMU_L  out  16  signed saturated left sample
- o_EMU_R  out  16  signed saturated right sample
- o_EMU_SAMPLE  out  1  high for exactly one tick when o_EMU_L/R update

## Operation
- Nothing changes on non-tick edges.
- Slot counter: 5 bits. On a tick with i_CYCLE_31, the counter loads 0; otherwise it increments and wraps 31→0.
- Accumulators acc_l and acc_r are 19-bit signed. Each tick with i_ACC_OPADD, sign-extended i_ACC_OPOUT is added to acc_l if i_RL[0] and to acc_r if i_RL[1].
- Frame end is a tick with i_CYCLE_31:
  - the slot-31 contribution is included;
  - the sum is saturated to 16-bit signed (>32767→32767, <−32768→−32768);
  - the result is loaded into hold_l/hold_r and o_EMU_L/R;
  - o_EMU_SAMPLE is set for that tick;
  - acc_l and acc_r are cleared to 0 rather than adding.
- Float encode of 16-bit s:
  - e is the smallest value in 1..7 such that s[15:8+e] are all equal to s[15];
  - m = s[8+e:e−1] (10-bit signed); decoded value = m·2^(e−1).
  - Zero encodes m=0, e=1.
- Serial word, 16 bits per channel, bit index = slot counter mod 16:
  - bits 0–2 are 0;
  - bits 3–12 are m[0..9];
  - bits 13–15 are e[0..2].
  - Slots 0–15 carry hold_l; slots 16–31 carry hold_r.
- o_SO is registered and presents the bit for the current counter value on each tick.

## Timing
- Reset values:
  - acc_l, acc_r, hold_l, hold_r: 0;
  - counter: 0;
  - o_SO: 0; o_EMU_L/R: 0; o_EMU_SAMPLE: 0.
- Reset is asynchronous and takes effect mid-frame. The first frame after reset is partial and ends at the next i_CYCLE_31 tick.
- Latency:
  - a sample accumulated in frame N appears on o_EMU_* at the frame-N end tick;
  - the same sample is serialised on o_SO during frame N+1, left word at slots 0–15, right at 16–31.
- The held zero sample after reset serialises as SO=1 only at bit 13 of each word.
- i_CYCLE_31 early or late by one slot: the counter resynchronises immediately. No error state exists.
- i_ACC_OPADD with i_RL=0: no accumulator change.

## Structure
- Shared package ika2151_pkg holds:
  - ACC_W=19, OUT_W=16, MANT_W=10, EXP_W=3;
  - the serial bit-position constants (pad 0–2, mantissa 3–12, exponent 13–15).
- The combinational float encoder is its own sub-module, ika2151_fpenc (16-bit signed in → 10-bit m, 3-bit e). It is instantiated twice, for L and R.
- Counter, accumulators, hold registers and serialiser stay in the top of the block.

## Test plan
- Reset, then run 2 frames with no adds → o_EMU_L/R=0, o_EMU_SAMPLE pulses once per 32 ticks, o_SO high only at slots 13 and 29.
- One carrier per frame, i_ACC_OPOUT=100, i_RL=2'b01 → o_EMU_L=100, o_EMU_R=0. Next frame, left word carries m=100, e=1.
- 32 adds of +8191 with i_RL=2'b11 → both channels saturate to 32767, encoded e=7, m=511. Repeat with −8192 → −32768, e=7, m=−512.
- Value 1000 (needs e=2) → m=500, e=2. Verify SO bits 3–15 are LSB-first 0x1F4 then 3'b010.
- Add on the i_CYCLE_31 tick (+5 in slot 31 only) → o_EMU_L=5 for that frame, and the next frame starts from 0.
- Assert i_MRST_n low at slot 10 → all outputs 0 immediately. After release, the partial frame sums only the post-reset adds.
